// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the 3x3 conv engine: reads a 3-channel frame, streams it, counts outputs.
// Optional macro SEQ_PERF_CNT_EN adds a busy-cycle counter on port cycle_count.
module conv_frame_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int WIDTH         = 56,
  parameter int HEIGHT        = 56,
  parameter int ADDR_WIDTH    = 12,
  parameter int OUT_PIXELS    = (WIDTH - 2) * (HEIGHT - 2),
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  hold,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data_0,
  input  logic [DATA_WIDTH-1:0] rd_data_1,
  input  logic [DATA_WIDTH-1:0] rd_data_2,
  output logic                  conv_valid_in,
  output logic [DATA_WIDTH-1:0] conv_data_0,
  output logic [DATA_WIDTH-1:0] conv_data_1,
  output logic [DATA_WIDTH-1:0] conv_data_2,
  input  logic                  conv_valid_out,
  input  logic                  conv_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           out_count
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [15:0] OUT_TARGET = 16'(OUT_PIXELS);
  localparam int TO_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  // Idle counter is cleared by a pulse (or by leaving FEED), so the limit
  // lands the done pulse DRAIN_TIMEOUT cycles after the last engine activity.
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(DRAIN_TIMEOUT - 2);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic            start_acc;
  logic            err_set;
  logic [15:0]     cnt_nxt;
  logic [TO_W-1:0] idle_cnt;
  logic            rd_vld_p1;
  logic [DATA_WIDTH-1:0] hold_0_p1, hold_1_p1, hold_2_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign busy = (state == S_FEED) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    start_acc = 1'b0;
    err_set   = 1'b0;
    cnt_nxt   = out_count;
    if (conv_valid_out && busy) cnt_nxt = sat_inc16(out_count);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FEED;
          start_acc = 1'b1;
        end
      end
      S_FEED: begin
        rd_en = !hold;
        if (!hold && rd_addr == LAST_ADDR) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_nxt == OUT_TARGET || conv_done) begin
          state_nxt = S_DONE;
        end else if (!conv_valid_out && idle_cnt == TO_LIMIT) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      out_count <= '0;
      err       <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        rd_addr   <= '0;
        out_count <= '0;
        err       <= 1'b0;
      end else begin
        out_count <= cnt_nxt;
        if (err_set) err <= 1'b1;
        if (rd_en && rd_addr != LAST_ADDR) rd_addr <= rd_addr + ADDR_WIDTH'(1);
      end
      if (state != S_DRAIN || conv_valid_out) idle_cnt <= '0;
      else if (idle_cnt != TO_LIMIT)          idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  // Stage p1: read data arrives one cycle after rd_en; pass it through while
  // valid and keep the last word on the engine inputs otherwise.
  always_ff @(posedge clk) begin
    if (resetn) begin
      rd_vld_p1 <= 1'b0;
      hold_0_p1 <= '0;
      hold_1_p1 <= '0;
      hold_2_p1 <= '0;
    end else begin
      rd_vld_p1 <= rd_en;
      if (rd_vld_p1) begin
        hold_0_p1 <= rd_data_0;
        hold_1_p1 <= rd_data_1;
        hold_2_p1 <= rd_data_2;
      end
    end
  end

  assign conv_valid_in = rd_vld_p1;
  assign conv_data_0   = rd_vld_p1 ? rd_data_0 : hold_0_p1;
  assign conv_data_1   = rd_vld_p1 ? rd_data_1 : hold_1_p1;
  assign conv_data_2   = rd_vld_p1 ? rd_data_2 : hold_2_p1;

`ifdef SEQ_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (resetn)         cycle_count <= '0;
    else if (start_acc) cycle_count <= '0;
    else if (busy)      cycle_count <= sat_inc32(cycle_count);
  end
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Randomized self-checking bench for conv_frame_sequencer (4x4 frame, 4 outputs, timeout 8).
// Compile with SEQ_PERF_CNT_EN defined to also exercise cycle_count.
module tb_conv_frame_sequencer;
  localparam int NPIX = 16;
  localparam int OUTP = 4;
  localparam int DTO  = 8;
  localparam int MAXC = 80;

  logic clk = 1'b0;
  logic resetn, start, hold, rd_en, conv_valid_in, conv_valid_out, conv_done, busy, done, err;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data_0, rd_data_1, rd_data_2, conv_data_0, conv_data_1, conv_data_2;
  logic [15:0] out_count;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_count;
`endif

  conv_frame_sequencer #(
    .DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4), .ADDR_WIDTH(4), .OUT_PIXELS(OUTP), .DRAIN_TIMEOUT(DTO)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .hold(hold),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .conv_valid_in(conv_valid_in),
    .conv_data_0(conv_data_0), .conv_data_1(conv_data_1), .conv_data_2(conv_data_2),
    .conv_valid_out(conv_valid_out), .conv_done(conv_done),
    .busy(busy), .done(done), .err(err), .out_count(out_count)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] mem0 [NPIX];
  logic [31:0] mem1 [NPIX];
  logic [31:0] mem2 [NPIX];
  bit st_pat [MAXC];
  bit hold_pat [MAXC];
  bit vo_pat [MAXC];
  bit cd_pat [MAXC];
  bit rst_pat [MAXC];
  logic        obs_rd_en [MAXC];
  logic [3:0]  obs_addr [MAXC];
  logic        obs_cvi [MAXC];
  logic [95:0] obs_cd [MAXC];
  logic        obs_busy [MAXC];
  logic        obs_done [MAXC];
  logic        obs_err [MAXC];
  logic [15:0] obs_cnt [MAXC];
  logic [31:0] obs_cyc [MAXC];
  logic        pend_v;
  logic [3:0]  pend_a;
  int m_rc [NPIX];
  int m_done, m_err, m_cnt;

  task automatic clr_pat();
    for (int c = 0; c < MAXC; c++) begin
      st_pat[c] = 0; hold_pat[c] = 0; vo_pat[c] = 0; cd_pat[c] = 0; rst_pat[c] = 0;
      obs_rd_en[c] = 0; obs_addr[c] = 0; obs_cvi[c] = 0; obs_cd[c] = 0;
      obs_busy[c] = 0; obs_done[c] = 0; obs_err[c] = 0; obs_cnt[c] = 0; obs_cyc[c] = 0;
    end
    for (int i = 0; i < NPIX; i++) begin
      mem0[i] = $urandom(); mem1[i] = $urandom(); mem2[i] = $urandom();
    end
  endtask

  task automatic place4(input int base);
    for (int i = 0; i < 4; i++) vo_pat[base + i*4 + int'($urandom_range(0, 3))] = 1;
  endtask

  // Frame buffer answers one cycle after rd_en; inputs change 1 time unit after the edge.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      rd_data_0 = pend_v ? mem0[pend_a] : $urandom();
      rd_data_1 = pend_v ? mem1[pend_a] : $urandom();
      rd_data_2 = pend_v ? mem2[pend_a] : $urandom();
      start = st_pat[c]; hold = hold_pat[c]; conv_valid_out = vo_pat[c];
      conv_done = cd_pat[c]; resetn = rst_pat[c];
      #1;
      obs_rd_en[c] = rd_en; obs_addr[c] = rd_addr; obs_cvi[c] = conv_valid_in;
      obs_cd[c] = {conv_data_0, conv_data_1, conv_data_2};
      obs_busy[c] = busy; obs_done[c] = done; obs_err[c] = err; obs_cnt[c] = out_count;
`ifdef SEQ_PERF_CNT_EN
      obs_cyc[c] = cycle_count;
`endif
      pend_v = rd_en; pend_a = rd_addr;
      @(posedge clk); #1;
    end
    start = 0; hold = 0; conv_valid_out = 0; conv_done = 0; resetn = 0;
  endtask

  // Reference: FEED reads the 16 pixels on non-hold cycles; DRAIN ends on the
  // 4th counted output, conv_done, or DTO cycles after the last activity.
  task automatic model_frame(input int s);
    int c, k, r, cnt;
    c = s + 1; k = 0; cnt = 0;
    m_done = MAXC - 1; m_err = 0;
    while (k < NPIX && c < MAXC - 1) begin
      if (!hold_pat[c]) begin m_rc[k] = c; k++; end
      cnt += int'(vo_pat[c]);
      c++;
    end
    r = m_rc[NPIX-1];
    for (c = r + 1; c < MAXC - 1; c++) begin
      cnt += int'(vo_pat[c]);
      if (cnt == OUTP || cd_pat[c]) begin m_done = c + 1; m_err = 0; break; end
      if (vo_pat[c]) r = c;
      else if (c - r == DTO - 1) begin m_done = c + 1; m_err = 1; break; end
    end
    m_cnt = cnt;
  endtask

  function automatic int done_pulses();
    int n = 0;
    for (int c = 0; c < MAXC; c++) if (obs_done[c] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_done();
    for (int c = 0; c < MAXC; c++) if (obs_done[c] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int rc_at(input int k);
    return (k >= 0 && k < NPIX) ? m_rc[k] : -1;
  endfunction

  task automatic test_reset();
    clr_pat();
    rst_pat[0] = 1; rst_pat[1] = 1;
    pend_v = 0;
    run(4);
    for (int c = 1; c < 4; c++) begin
      n_checks++;
      if ({obs_rd_en[c], obs_addr[c], obs_cvi[c], obs_cd[c], obs_busy[c], obs_done[c], obs_err[c], obs_cnt[c], obs_cyc[c]} !== '0)
        begin n_errs++; $display("FAIL reset_state cyc=%0d rd_en=%b addr=%0d cvi=%b data=%h busy=%b done=%b err=%b cnt=%0d cyc=%0d expected all zero",
          c, obs_rd_en[c], obs_addr[c], obs_cvi[c], obs_cd[c], obs_busy[c], obs_done[c], obs_err[c], obs_cnt[c], obs_cyc[c]); end
    end
  endtask

  task automatic test_basic();
    int k;
    clr_pat();
    st_pat[1] = 1; place4(7);
    model_frame(1);
    run(45);
    k = 0;
    for (int c = 0; c < 45; c++) if (obs_rd_en[c] === 1'b1) begin
      n_checks++;
      if (obs_addr[c] !== 4'(k) || c != rc_at(k)) begin n_errs++;
        $display("FAIL basic_read #%0d got addr=%0d cyc=%0d expected addr=%0d cyc=%0d", k, obs_addr[c], c, k, rc_at(k)); end
      k++;
    end
    n_checks++;
    if (k != NPIX) begin n_errs++; $display("FAIL basic_read_count got %0d expected %0d", k, NPIX); end
    k = 0;
    for (int c = 0; c < 45; c++) if (obs_cvi[c] === 1'b1) begin
      n_checks++;
      if (k >= NPIX || c != rc_at(k) + 1 || obs_cd[c] !== {mem0[k], mem1[k], mem2[k]}) begin n_errs++;
        $display("FAIL basic_stream #%0d cyc=%0d data=%h expected cyc=%0d", k, c, obs_cd[c], rc_at(k) + 1); end
      k++;
    end
    n_checks++;
    if (k != NPIX) begin n_errs++; $display("FAIL basic_stream_count got %0d expected %0d", k, NPIX); end
    n_checks++;
    if (done_pulses() != 1 || first_done() != m_done) begin n_errs++;
      $display("FAIL basic_done pulses=%0d at=%0d expected 1 at %0d", done_pulses(), first_done(), m_done); end
    n_checks++;
    if ({obs_busy[1], obs_busy[2], obs_busy[m_done], obs_err[m_done], obs_cnt[m_done]} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'd4}) begin n_errs++;
      $display("FAIL basic_status busy@s=%b busy@s+1=%b busy@done=%b err=%b cnt=%0d expected 0 1 0 0 4",
        obs_busy[1], obs_busy[2], obs_busy[m_done], obs_err[m_done], obs_cnt[m_done]); end
  endtask

  task automatic test_hold();
    int k;
    clr_pat();
    st_pat[1] = 1; hold_pat[7] = 1; hold_pat[8] = 1; hold_pat[9] = 1; place4(9);
    model_frame(1);
    run(45);
    for (int c = 7; c <= 9; c++) begin
      n_checks++;
      if (obs_addr[c] !== 4'd5 || obs_rd_en[c] !== 1'b0 || obs_cvi[c+1] !== 1'b0) begin n_errs++;
        $display("FAIL hold_stall cyc=%0d addr=%0d rd_en=%b cvi_next=%b expected 5 0 0", c, obs_addr[c], obs_rd_en[c], obs_cvi[c+1]); end
    end
    n_checks++;
    if (obs_cvi[7] !== 1'b1 || obs_cvi[11] !== 1'b1) begin n_errs++;
      $display("FAIL hold_gap_edges cvi7=%b cvi11=%b expected 1 1", obs_cvi[7], obs_cvi[11]); end
    k = 0;
    for (int c = 0; c < 45; c++) if (obs_cvi[c] === 1'b1) begin
      n_checks++;
      if (k >= NPIX || obs_cd[c] !== {mem0[k], mem1[k], mem2[k]}) begin n_errs++;
        $display("FAIL hold_stream #%0d data=%h", k, obs_cd[c]); end
      k++;
    end
    n_checks++;
    if (k != NPIX || done_pulses() != 1 || first_done() != m_done) begin n_errs++;
      $display("FAIL hold_frame words=%0d done_at=%0d expected %0d at %0d", k, first_done(), NPIX, m_done); end
  endtask

  task automatic test_timeout();
    int p1, p2;
    clr_pat();
    st_pat[1] = 1;
    p1 = 18 + int'($urandom_range(0, 2));
    p2 = p1 + 1 + int'($urandom_range(0, 3));
    vo_pat[p1] = 1; vo_pat[p2] = 1;
    run(45);
    n_checks++;
    if (done_pulses() != 1 || first_done() != p2 + DTO) begin n_errs++;
      $display("FAIL timeout_done pulses=%0d at=%0d expected 1 at %0d", done_pulses(), first_done(), p2 + DTO); end
    n_checks++;
    if (obs_err[p2 + DTO] !== 1'b1 || obs_err[p2 + DTO - 1] !== 1'b0 || obs_cnt[p2 + DTO] !== 16'd2) begin n_errs++;
      $display("FAIL timeout_status err=%b err_before=%b cnt=%0d expected 1 0 2", obs_err[p2 + DTO], obs_err[p2 + DTO - 1], obs_cnt[p2 + DTO]); end
    n_checks++;
    if (obs_err[p2 + DTO + 4] !== 1'b1 || obs_cnt[p2 + DTO + 4] !== 16'd2) begin n_errs++;
      $display("FAIL timeout_sticky err=%b cnt=%0d expected 1 2", obs_err[p2 + DTO + 4], obs_cnt[p2 + DTO + 4]); end
  endtask

  task automatic test_ignored_start();
    int k, bad, dn;
    clr_pat();
    st_pat[1] = 1; st_pat[6] = 1; vo_pat[11] = 1;
    model_frame(1);
    dn = m_done;
    st_pat[dn] = 1;
    run(40);
    k = 0; bad = 0;
    for (int c = 0; c < 40; c++) if (obs_rd_en[c] === 1'b1) begin
      if (obs_addr[c] !== 4'(k)) bad++;
      k++;
    end
    n_checks++;
    if (k != NPIX || bad != 0) begin n_errs++; $display("FAIL ign_reads count=%0d bad=%0d expected 16 0", k, bad); end
    n_checks++;
    if (done_pulses() != 1 || first_done() != dn) begin n_errs++;
      $display("FAIL ign_done pulses=%0d at=%0d expected 1 at %0d", done_pulses(), first_done(), dn); end
    n_checks++;
    if ({obs_busy[dn+1], obs_rd_en[dn+1], obs_err[dn+2], obs_cnt[dn+2]} !== {1'b0, 1'b0, 1'(m_err), 16'(m_cnt)}) begin n_errs++;
      $display("FAIL ign_after busy=%b rd_en=%b err=%b cnt=%0d expected 0 0 %0d %0d",
        obs_busy[dn+1], obs_rd_en[dn+1], obs_err[dn+2], obs_cnt[dn+2], m_err, m_cnt); end
    clr_pat();
    st_pat[1] = 1; place4(7);
    model_frame(1);
    run(45);
    n_checks++;
    if (obs_err[2] !== 1'b0 || obs_cnt[2] !== 16'd0) begin n_errs++;
      $display("FAIL ign_restart_clear err=%b cnt=%0d expected 0 0", obs_err[2], obs_cnt[2]); end
    n_checks++;
    if (done_pulses() != 1 || first_done() != m_done || obs_cnt[m_done] !== 16'd4 || obs_err[m_done] !== 1'b0) begin n_errs++;
      $display("FAIL ign_restart_frame done_at=%0d cnt=%0d err=%b expected %0d 4 0", first_done(), obs_cnt[m_done], obs_err[m_done], m_done); end
  endtask

  task automatic test_mid_reset();
    clr_pat();
    st_pat[1] = 1; rst_pat[11] = 1; vo_pat[8] = 1;
    run(25);
    n_checks++;
    if (obs_addr[11] !== 4'd9 || obs_rd_en[11] !== 1'b1) begin n_errs++;
      $display("FAIL rst_at_addr addr=%0d rd_en=%b expected 9 1", obs_addr[11], obs_rd_en[11]); end
    n_checks++;
    if ({obs_rd_en[12], obs_addr[12], obs_cvi[12], obs_cd[12], obs_busy[12], obs_done[12], obs_err[12], obs_cnt[12], obs_cyc[12]} !== '0)
      begin n_errs++; $display("FAIL rst_outputs rd_en=%b addr=%0d cvi=%b data=%h busy=%b cnt=%0d expected all zero",
        obs_rd_en[12], obs_addr[12], obs_cvi[12], obs_cd[12], obs_busy[12], obs_cnt[12]); end
    n_checks++;
    if (done_pulses() != 0 || obs_busy[20] !== 1'b0) begin n_errs++;
      $display("FAIL rst_no_done pulses=%0d busy=%b expected 0 0", done_pulses(), obs_busy[20]); end
    clr_pat();
    st_pat[1] = 1; place4(7);
    model_frame(1);
    run(45);
    n_checks++;
    if (obs_rd_en[2] !== 1'b1 || obs_addr[2] !== 4'd0 || done_pulses() != 1 || first_done() != m_done) begin n_errs++;
      $display("FAIL rst_rerun rd_en=%b addr=%0d done_at=%0d expected 1 0 %0d", obs_rd_en[2], obs_addr[2], first_done(), m_done); end
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic test_perf();
    clr_pat();
    st_pat[1] = 1; hold_pat[5] = 1; hold_pat[6] = 1; place4(9);
    model_frame(1);
    run(45);
    n_checks++;
    if (obs_cyc[2] !== 32'd0) begin n_errs++; $display("FAIL perf_clear got %0d expected 0", obs_cyc[2]); end
    n_checks++;
    if (obs_cyc[m_done] !== 32'(m_done - 2) || obs_cyc[m_done + 4] !== 32'(m_done - 2)) begin n_errs++;
      $display("FAIL perf_count at_done=%0d later=%0d expected %0d", obs_cyc[m_done], obs_cyc[m_done + 4], m_done - 2); end
  endtask
`endif

  task automatic test_random();
    int k, bad, np;
    for (int it = 0; it < 4; it++) begin
      clr_pat();
      st_pat[1] = 1;
      for (int c = 2; c < 42; c++) hold_pat[c] = ($urandom_range(0, 3) == 0);
      np = int'($urandom_range(0, 4));
      for (int i = 0; i < np; i++) vo_pat[i*7 + int'($urandom_range(0, 6))] = 1;
      model_frame(1);
      if ($urandom_range(0, 2) == 0) cd_pat[m_rc[NPIX-1] + 1 + int'($urandom_range(0, 4))] = 1;
      model_frame(1);
      run(78);
      k = 0; bad = 0;
      for (int c = 0; c < 78; c++) if (obs_rd_en[c] === 1'b1) begin
        if (obs_addr[c] !== 4'(k) || c != rc_at(k) || hold_pat[c]) bad++;
        k++;
      end
      n_checks++;
      if (k != NPIX || bad != 0) begin n_errs++; $display("FAIL rand_reads it=%0d count=%0d bad=%0d", it, k, bad); end
      k = 0; bad = 0;
      for (int c = rc_at(0) + 1; c <= m_done; c++) begin
        if (obs_cvi[c] === 1'b1) begin
          if (k >= NPIX || c != rc_at(k) + 1 || obs_cd[c] !== {mem0[k], mem1[k], mem2[k]}) bad++;
          k++;
        end else if (obs_cd[c] !== {mem0[k-1], mem1[k-1], mem2[k-1]}) bad++;
      end
      n_checks++;
      if (k != NPIX || bad != 0) begin n_errs++; $display("FAIL rand_stream it=%0d words=%0d bad=%0d", it, k, bad); end
      n_checks++;
      if (done_pulses() != 1 || first_done() != m_done) begin n_errs++;
        $display("FAIL rand_done it=%0d pulses=%0d at=%0d expected 1 at %0d", it, done_pulses(), first_done(), m_done); end
      n_checks++;
      if ({obs_busy[m_done], obs_err[m_done], obs_cnt[m_done], obs_err[m_done+1], obs_cnt[m_done+1]} !==
          {1'b0, 1'(m_err), 16'(m_cnt), 1'(m_err), 16'(m_cnt)}) begin n_errs++;
        $display("FAIL rand_status it=%0d busy=%b err=%b cnt=%0d expected 0 %0d %0d", it, obs_busy[m_done], obs_err[m_done], obs_cnt[m_done], m_err, m_cnt); end
    end
  endtask

  initial begin
    resetn = 1; start = 0; hold = 0; conv_valid_out = 0; conv_done = 0;
    rd_data_0 = 0; rd_data_1 = 0; rd_data_2 = 0; pend_v = 0; pend_a = 0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_hold();
    test_timeout();
    test_ignored_start();
    test_mid_reset();
`ifdef SEQ_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
